// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF LCU feeder: image/parameter geometry,
// LCU size decoding and FSM state encoding.
package ipf_pkg;
    localparam int IMG_LOG2 = 7;
    localparam int PIX_W    = 8;
    localparam int PRM_W    = 24;
    localparam int ADDR_W   = 2 * IMG_LOG2;

    // Parameter word layout: {ipf_type, band_pos, wo_class, offset}
    localparam int PRM_TYPE_LSB = 22;
    localparam int PRM_BAND_LSB = 17;
    localparam int PRM_WO_BIT   = 16;
    localparam int PRM_OFF_LSB  = 0;

    localparam logic [1:0] SZ_16 = 2'd0;
    localparam logic [1:0] SZ_32 = 2'd1;
    localparam logic [1:0] SZ_64 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PFETCH = 3'd1,
        S_PLATCH = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [1:0] norm_size(input logic [1:0] cfg);
        return (cfg == 2'd3) ? SZ_64 : cfg;
    endfunction

    // log2 of the LCU edge length N
    function automatic logic [2:0] n_log2(input logic [1:0] sz);
        case (sz)
            SZ_16:   return 3'd4;
            SZ_32:   return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic [5:0] n_max(input logic [1:0] sz);
        return 6'((7'd1 << n_log2(sz)) - 7'd1);
    endfunction

    function automatic logic [2:0] l_max(input logic [1:0] sz);
        return 3'((4'd1 << (3'd7 - n_log2(sz))) - 4'd1);
    endfunction
endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// Filter-side pixel bus of the LCU feeder: pixel beat, per-LCU sideband
// and the filter's busy throttle.
interface ipf_lcu_feeder_if;
    import ipf_pkg::*;

    // in_en marks a valid din beat and cannot be refused on that cycle; busy
    // only stops new image reads, so one beat already in flight still arrives.
    logic             busy;
    logic             in_en;
    logic [PIX_W-1:0] din;
    logic [1:0]       ipf_type;
    logic [4:0]       ipf_band_pos;
    logic             ipf_wo_class;
    logic [15:0]      ipf_offset;
    logic [2:0]       lcu_x;
    logic [2:0]       lcu_y;
    logic [1:0]       lcu_size;

    modport master (
        input  busy,
        output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size
    );

    modport slave (
        output busy,
        input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size
    );
endinterface

// File: rtl/ipf_lcu_scan_ctr.sv
// LCU raster scan counters: col/row inside an LCU, then lcu_x/lcu_y across
// the image, with wrap points set by the LCU size code.
module ipf_lcu_scan_ctr
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              adv,
    input  logic [1:0]        size,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [5:0]        lcu_idx,
    output logic [ADDR_W-1:0] img_addr,
    output logic              first_pix,
    output logic              last_pix,
    output logic              last_lcu
);
    logic [5:0]          row;
    logic [5:0]          col;
    logic [5:0]          nmax;
    logic [2:0]          lmax;
    logic [2:0]          nsh;
    logic [IMG_LOG2-1:0] img_row;
    logic [IMG_LOG2-1:0] img_col;

    assign nsh  = n_log2(size);
    assign nmax = n_max(size);
    assign lmax = l_max(size);

    // N is a power of two, so lcu*N + offset is a shift OR'd with the offset
    assign img_row  = ({4'b0, lcu_y} << nsh) | {1'b0, row};
    assign img_col  = ({4'b0, lcu_x} << nsh) | {1'b0, col};
    assign img_addr = {img_row, img_col};
    assign lcu_idx  = ({3'b0, lcu_y} << (3'd7 - nsh)) | {3'b0, lcu_x};

    assign first_pix = (row == '0) && (col == '0);
    assign last_pix  = (row == nmax) && (col == nmax);
    assign last_lcu  = (lcu_x == lmax) && (lcu_y == lmax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row   <= '0;
            col   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (clear) begin
            row   <= '0;
            col   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (adv) begin
            if (col != nmax) begin
                col <= col + 6'd1;
            end else begin
                col <= '0;
                if (row != nmax) begin
                    row <= row + 6'd1;
                end else begin
                    row <= '0;
                    if (lcu_x != lmax) begin
                        lcu_x <= lcu_x + 3'd1;
                    end else begin
                        lcu_x <= '0;
                        lcu_y <= (lcu_y == lmax) ? 3'd0 : lcu_y + 3'd1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 image to the IPF filter in LCU raster order with the
// per-LCU parameters prefetched one LCU ahead.
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_q,
    output logic              prm_rd,
    output logic [5:0]        prm_addr,
    input  logic [PRM_W-1:0]  prm_q,
    output logic              active,
    output logic              done,
    ipf_lcu_feeder_if.master  fil,
    output state_t            dbg_state
);
    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [1:0]        size_q;
    logic              rd_q;
    logic              prm_rd_q;
    logic [PRM_W-1:0]  next_prm;
    logic [PRM_W-1:0]  sb_prm;
    logic [2:0]        sb_x;
    logic [2:0]        sb_y;
    logic [2:0]        lcu_x;
    logic [2:0]        lcu_y;
    logic [5:0]        lcu_idx;
    logic              first_pix;
    logic              last_pix;
    logic              last_lcu;

    ipf_lcu_scan_ctr u_scan (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .adv       (img_rd),
        .size      (size_q),
        .lcu_x     (lcu_x),
        .lcu_y     (lcu_y),
        .lcu_idx   (lcu_idx),
        .img_addr  (img_addr),
        .first_pix (first_pix),
        .last_pix  (last_pix),
        .last_lcu  (last_lcu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        img_rd    = 1'b0;
        prm_rd    = 1'b0;
        prm_addr  = '0;
        active    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_PFETCH;
                end
            end
            S_PFETCH: begin
                active    = 1'b1;
                prm_rd    = 1'b1;
                state_nxt = S_PLATCH;
            end
            S_PLATCH: begin
                active    = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                active = 1'b1;
                if (!fil.busy) begin
                    img_rd = 1'b1;
                    // First read of an LCU fetches the parameters of the next one
                    if (first_pix && !last_lcu) begin
                        prm_rd   = 1'b1;
                        prm_addr = lcu_idx + 6'd1;
                    end
                    if (last_pix && last_lcu) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                active    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q   <= '0;
            rd_q     <= 1'b0;
            prm_rd_q <= 1'b0;
            next_prm <= '0;
            sb_prm   <= '0;
            sb_x     <= '0;
            sb_y     <= '0;
        end else begin
            if (accept) size_q <= norm_size(cfg_lcu_size);
            rd_q     <= img_rd;
            prm_rd_q <= prm_rd;
            if (prm_rd_q) next_prm <= prm_q;
            // Sideband switches exactly when the LCU's first pixel is delivered
            if (img_rd && first_pix) begin
                sb_prm <= next_prm;
                sb_x   <= lcu_x;
                sb_y   <= lcu_y;
            end
        end
    end

    assign fil.in_en        = rd_q;
    assign fil.din          = rd_q ? img_q : '0;
    assign fil.ipf_type     = sb_prm[PRM_TYPE_LSB +: 2];
    assign fil.ipf_band_pos = sb_prm[PRM_BAND_LSB +: 5];
    assign fil.ipf_wo_class = sb_prm[PRM_WO_BIT];
    assign fil.ipf_offset   = sb_prm[PRM_OFF_LSB +: 16];
    assign fil.lcu_x        = sb_x;
    assign fil.lcu_y        = sb_y;
    assign fil.lcu_size     = size_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Bench for ipf_lcu_feeder: memories, a per-pixel expected stream built from
// the LCU raster rules, and a negedge compare process.
module tb_ipf_lcu_feeder;
    import ipf_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg = 2'd0;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q = 8'd0;
    logic        prm_rd;
    logic [5:0]  prm_addr;
    logic [23:0] prm_q = 24'd0;
    logic        active;
    logic        done;
    state_t      dbg_state;
    int          cyc = 0;

    ipf_lcu_feeder_if fif ();

    ipf_lcu_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_q        (img_q),
        .prm_rd       (prm_rd),
        .prm_addr     (prm_addr),
        .prm_q        (prm_q),
        .active       (active),
        .done         (done),
        .fil          (fif),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memories ----------------
    logic [7:0]  img_mem [16384];
    logic [23:0] prm_mem [64];

    always @(posedge clk) begin
        if (img_rd) img_q <= img_mem[img_addr];
        if (prm_rd) prm_q <= prm_mem[prm_addr];
    end

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q[$];
    logic [13:0] exp_addr_q[$];
    int          tests = 0;
    int          fails = 0;
    int          prm_cnt, pix_n, done_cnt, first_cyc, done_cyc, run_nn;
    bit          seen;
    logic [29:0] last_sb;
    logic [7:0]  din_log [512];
    logic [2:0]  lx_log [512];
    logic [29:0] first_sb [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_extra(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT produced a beat with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Expected stream: LCUs raster across the image, pixels raster inside each LCU
    task automatic build_model(input int sz);
        int n, l;
        logic [13:0] a;
        n = (sz == 0) ? 16 : (sz == 1) ? 32 : 64;
        l = 128 / n;
        run_nn = n * n;
        exp_q.delete();
        exp_addr_q.delete();
        prm_cnt = 0; pix_n = 0; seen = 0; done_cnt = 0; first_cyc = 0; done_cyc = 0;
        for (int ly = 0; ly < l; ly++)
            for (int lx = 0; lx < l; lx++)
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++) begin
                        a = 14'((ly * n + r) * 128 + lx * n + c);
                        exp_addr_q.push_back(a);
                        exp_q.push_back({img_mem[a], prm_mem[ly * l + lx], 3'(lx), 3'(ly)});
                    end
    endtask

    always @(negedge clk) begin
        logic [37:0] act;
        if (!reset) begin
            if (img_rd) begin
                if (exp_addr_q.size() == 0) flag_extra("extra_read");
                else chk("img_addr", img_addr, exp_addr_q.pop_front());
            end
            if (prm_rd) begin
                chk("prm_addr", prm_addr, prm_cnt);
                prm_cnt++;
            end
            act = {fif.din, fif.ipf_type, fif.ipf_band_pos, fif.ipf_wo_class,
                   fif.ipf_offset, fif.lcu_x, fif.lcu_y};
            if (fif.in_en) begin
                if (exp_q.size() == 0) flag_extra("extra_pixel");
                else chk("pixel", act, exp_q.pop_front());
                if (pix_n < 512) begin
                    din_log[pix_n] = fif.din;
                    lx_log[pix_n]  = fif.lcu_x;
                end
                if ((pix_n % run_nn) == 0 && (pix_n / run_nn) < 64)
                    first_sb[pix_n / run_nn] = act[29:0];
                if (pix_n == 0) first_cyc = cyc;
                pix_n++;
                last_sb = act[29:0];
                seen = 1'b1;
            end else if (seen) begin
                chk("sideband_hold", act[29:0], last_sb);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_zero(input string name);
        chk(name, {img_rd, img_addr, prm_rd, prm_addr, fif.in_en, fif.din, fif.ipf_type,
                   fif.ipf_band_pos, fif.ipf_wo_class, fif.ipf_offset, fif.lcu_x,
                   fif.lcu_y, fif.lcu_size, active, done}, 64'd0);
    endtask

    task automatic run_image(input int sz, input bit rand_busy, input int busy_at,
                             input int busy_len, input int start_at, output int c0);
        int n, r;
        n = (sz == 0) ? 16 : (sz == 1) ? 32 : 64;
        build_model(sz);
        @(posedge clk); #1;
        c0 = cyc;
        cfg = 2'(sz);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg = 2'($urandom_range(0, 3));
        while (done_cnt == 0 && cyc - c0 < 40000) begin
            r = cyc - c0;
            fif.busy = rand_busy ? ($urandom_range(0, 7) == 0)
                                 : (r >= busy_at && r < busy_at + busy_len);
            start = (r == start_at);
            @(posedge clk); #1;
        end
        fif.busy = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("pixels_left", exp_q.size(), 0);
        chk("reads_left", exp_addr_q.size(), 0);
        chk("prm_reads", prm_cnt, (128 / n) * (128 / n));
        chk("lcu_size", fif.lcu_size, (sz == 3) ? 2 : sz);
        chk("active_after", active, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        logic [13:0] a;
        fif.busy = 1'b0;

        for (int k = 0; k < 16384; k++) begin
            a = 14'(k);
            img_mem[k] = 8'(a[13:7] + a[6:0]);
        end
        for (int k = 0; k < 64; k++) prm_mem[k] = 24'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b0;

        // Size 16, ramp image, start pulsed mid-stream must be ignored
        run_image(0, 1'b0, -10, 0, 5000, c0);
        chk("s16_first_in_en", first_cyc - c0, 4);
        chk("s16_done_cycle", done_cyc - c0, 16388);
        chk("s16_din0", din_log[0], 8'd0);
        chk("s16_din15", din_log[15], 8'd15);
        chk("s16_din16", din_log[16], 8'd1);
        chk("s16_lx_pix256", lx_log[255], 3'd0);
        chk("s16_lx_pix257", lx_log[256], 3'd1);

        // Size code 3 behaves as 64, known parameter table, random busy
        for (int k = 0; k < 16384; k++) img_mem[k] = 8'($urandom);
        for (int k = 0; k < 64; k++) begin
            a = 14'(k);
            prm_mem[k] = {2'd1, a[4:0], a[0], 16'(16'h1234 + k)};
        end
        run_image(3, 1'b1, 0, 0, -1, c0);
        chk("s64_lcu1_x", first_sb[1][5:3], 3'd1);
        chk("s64_lcu1_y", first_sb[1][2:0], 3'd0);
        chk("s64_lcu2_y", first_sb[2][2:0], 3'd1);
        chk("s64_lcu3_xy", first_sb[3][5:0], 6'o11);
        chk("s64_lcu3_offset", first_sb[3][21:6], 16'h1237);
        chk("s64_lcu2_type", first_sb[2][29:28], 2'd1);
        chk("s64_stream_prm_rd", prm_cnt - 1, 3);

        // Size 32 with a 5-cycle busy window right after pixel 300 is read
        for (int k = 0; k < 16384; k++) img_mem[k] = 8'($urandom);
        for (int k = 0; k < 64; k++) prm_mem[k] = 24'($urandom);
        run_image(1, 1'b0, 304, 5, -1, c0);
        chk("s32_first_in_en", first_cyc - c0, 4);
        chk("s32_done_cycle", done_cyc - c0, 16393);

        // Reset mid-stream at cycle 1000 of a size-64 run
        build_model(2);
        @(posedge clk); #1;
        c0 = cyc;
        cfg = 2'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - c0 < 1000) begin
            @(posedge clk); #1;
        end
        chk("rst_pixels_before", pix_n, 996);
        chk("rst_size_latched", fif.lcu_size, 2'd2);
        reset = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        chk_zero("rst_outputs");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt, 0);
        chk_zero("rst_idle_outputs");

        // Clean size-16 run, busy held while LCU 63's first pixel would be read
        for (int k = 0; k < 16384; k++) img_mem[k] = 8'($urandom);
        for (int k = 0; k < 64; k++) prm_mem[k] = 24'($urandom);
        run_image(0, 1'b0, 16131, 3, -1, c0);
        chk("post_rst_first_in_en", first_cyc - c0, 4);
        chk("lcu63_done_cycle", done_cyc - c0, 16391);
        chk("lcu63_sideband", first_sb[63], {prm_mem[63], 3'd7, 3'd7});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
